i2c_master_ctrl: RTL

Synthesizable single-master I2C controller that drives the open-drain Scl/Sda bus of the sensor slave (slave model, BME280-style timing). It accepts one register-level command (write one byte, or read one byte) on a valid/ready interface. It serialises the command as START, bytes, ACK slots, optional repeated START, and STOP, then returns read data and an ACK status. The top level converts scl_oe/sda_oe into tri-states: a line is driven 0 when oe=1 and is 'z' otherwise, with an external pull-up.

---
 rtl/i2c_master_ctrl_pkg.sv | 45 ++++
 rtl/i2c_quarter_tick.sv | 33 +++
 rtl/i2c_master_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared definitions for the I2C master controller: FSM states, quarter-phase
// encodings, byte step indices, transfer lengths and the command payload.
package i2c_master_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_RX_ACK,
    ST_RSTART,
    ST_RX_BYTE,
    ST_TX_NACK,
    ST_STOP,
    ST_DONE
  } state_e;

  // Quarter phases within one SCL bit period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Byte step indices
  localparam logic [1:0] STEP_DEV_W = 2'd0;  // {dev,0}
  localparam logic [1:0] STEP_REG   = 2'd1;  // register address
  localparam logic [1:0] STEP_DATA  = 2'd2;  // wdata (write) or repeated START (read)
  localparam logic [1:0] STEP_DEV_R = 2'd3;  // {dev,1}

  // Bit periods per complete transfer
  localparam int unsigned WR_BITS = 29;
  localparam int unsigned RD_BITS = 39;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } cmd_t;

  // Bit periods of an un-NACKed transfer of the given direction
  function automatic int unsigned xfer_bits(input logic rw);
    return rw ? RD_BITS : WR_BITS;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit prescaler: pulses tick_c on the last clk of every CLK_DIV-clk
// quarter and advances the 2-bit quarter index on that pulse.
// Ports: clk, rst (sync, active-high), clr (sync realign to Q0/count 0),
//        tick_c (combinational end-of-quarter strobe), quarter (current Q0..Q3).
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick_c,
  output logic [1:0] quarter
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_c = (cnt_q == DIV_W'(CLK_DIV - 1));

  // Divider and quarter index
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q   <= '0;
      quarter <= 2'd0;
    end else if (tick_c) begin
      cnt_q   <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller executing one register write or register read
// per command. Bus pins are open-drain enables; the pad ring turns oe=1 into
// a driven 0 and oe=0 into 'z' with an external pull-up.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_rw, cmd_dev_addr,
//   cmd_reg_addr, cmd_wdata       command fields (captured on accept)
//   rsp_valid                     one-cycle completion pulse
//   rsp_rdata, rsp_nack           read byte / NACK status, held between pulses
//   scl_oe, sda_oe                1 = pull the line low
//   sda_i                         sampled SDA bus level
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] step_q, step_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
  logic       sda_pre_q, sda_pre_d;
  logic       cmd_ready_d, rsp_valid_d, rsp_nack_d, scl_oe_d;
  logic [7:0] rsp_rdata_d;

  logic       tick_c;
  logic [1:0] quarter;
  logic       accept_c, launch_c, q2_end_c, bit_end_c;

  assign accept_c  = cmd_valid && cmd_ready;
  // A captured command waits one cycle in IDLE before the bus sequence starts
  assign launch_c  = (state_q == ST_IDLE) && !cmd_ready;
  assign q2_end_c  = tick_c && (quarter == Q2);
  assign bit_end_c = tick_c && (quarter == Q3);

  // Prescaler is held at Q0/count 0 while idle so every transfer starts aligned
  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_IDLE),
    .tick_c  (tick_c),
    .quarter (quarter)
  );

  // Next-state, datapath and bus-level decode
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    step_d      = step_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_nack_d  = rsp_nack;
    scl_oe_d    = 1'b0;
    sda_pre_d   = 1'b0;

    if (q2_end_c) begin
      ack_d = sda_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cmd_d       = {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata};
          cmd_ready_d = 1'b0;
        end else if (launch_c) begin
          state_d = ST_START;
          nack_d  = 1'b0;
          step_d  = STEP_DEV_W;
          bit_d   = 3'd0;
        end
      end

      ST_START: begin
        // SDA falls while SCL high (Q2), then SCL falls (Q3)
        scl_oe_d  = (quarter == Q3);
        sda_pre_d = quarter[1];
        if (bit_end_c) begin
          state_d = ST_TX_BYTE;
          tx_d    = {cmd_q.dev_addr, 1'b0};
          bit_d   = 3'd0;
        end
      end

      ST_TX_BYTE: begin
        scl_oe_d  = !quarter[1];
        sda_pre_d = !tx_q[7];
        if (bit_end_c) begin
          if (bit_q == 3'd7) begin
            state_d = ST_RX_ACK;
          end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
          end
        end
      end

      ST_RX_ACK: begin
        scl_oe_d = !quarter[1];
        if (bit_end_c) begin
          bit_d = 3'd0;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            unique case (step_q)
              STEP_DEV_W: begin
                step_d  = STEP_REG;
                tx_d    = cmd_q.reg_addr;
                state_d = ST_TX_BYTE;
              end
              STEP_REG: begin
                step_d = STEP_DATA;
                if (cmd_q.rw) begin
                  state_d = ST_RSTART;
                end else begin
                  tx_d    = cmd_q.wdata;
                  state_d = ST_TX_BYTE;
                end
              end
              STEP_DATA:  state_d = ST_STOP;
              STEP_DEV_R: state_d = ST_RX_BYTE;
              default:    state_d = ST_STOP;
            endcase
          end
        end
      end

      ST_RSTART: begin
        // SCL low with SDA released, SCL high, then SDA falls under high SCL
        scl_oe_d  = (quarter == Q0);
        sda_pre_d = (quarter == Q3);
        if (bit_end_c) begin
          step_d  = STEP_DEV_R;
          tx_d    = {cmd_q.dev_addr, 1'b1};
          bit_d   = 3'd0;
          state_d = ST_TX_BYTE;
        end
      end

      ST_RX_BYTE: begin
        scl_oe_d = !quarter[1];
        if (q2_end_c) begin
          rx_d = {rx_q[6:0], sda_i};
        end
        if (bit_end_c) begin
          if (bit_q == 3'd7) begin
            state_d = ST_TX_NACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      ST_TX_NACK: begin
        scl_oe_d = !quarter[1];
        if (bit_end_c) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        // SDA held low through SCL rise, released in Q3
        scl_oe_d  = !quarter[1];
        sda_pre_d = (quarter != Q3);
        if (bit_end_c) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        cmd_ready_d = 1'b1;
        rsp_nack_d  = nack_q;
        if (cmd_q.rw && !nack_q) begin
          rsp_rdata_d = rx_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; SDA passes one extra stage so it never
  // changes on the same clk as SCL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      step_q    <= STEP_DEV_W;
      bit_q     <= 3'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      sda_pre_q <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_nack  <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      step_q    <= step_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      sda_pre_q <= sda_pre_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_nack  <= rsp_nack_d;
      scl_oe    <= scl_oe_d;
      sda_oe    <= sda_pre_q;
    end
  end

endmodule
